// File: rtl/conv_window_feeder.sv
// Serialises one captured pixel/weight window onto o_pixel/o_weight, one tap per clock starting the cycle after the handshake,
// then zero-fills DRAIN_CYCLES cycles; o_ready is high only in IDLE, and new windows are refused while a window streams or drains.
module conv_window_feeder #(
    parameter int WIDTH        = 32,
    parameter int TAPS         = 9,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [TAPS*WIDTH-1:0]   i_window,
    input  logic [TAPS*WIDTH-1:0]   i_weights,
    output logic [WIDTH-1:0]        o_pixel,
    output logic [WIDTH-1:0]        o_weight,
    output logic                    o_valid,
    output logic                    o_first,
    output logic                    o_last,
    output logic                    o_done
);
    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [TW-1:0] LAST_TAP   = TW'(TAPS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tap_q, tap_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [WIDTH-1:0] pix_buf_q [TAPS];
    logic [WIDTH-1:0] wt_buf_q  [TAPS];
    logic [WIDTH-1:0] pixel_q, pixel_d;
    logic [WIDTH-1:0] weight_q, weight_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             accept;

    assign o_ready = (state_q == IDLE) && !rst;
    assign accept  = i_valid && o_ready;

    // tap_q / drain_q always index the word currently presented on the outputs
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        drain_d  = drain_q;
        pixel_d  = '0;
        weight_d = '0;
        valid_d  = 1'b0;
        first_d  = 1'b0;
        last_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = STREAM;
                    tap_d    = '0;
                    pixel_d  = i_window[0 +: WIDTH];
                    weight_d = i_weights[0 +: WIDTH];
                    valid_d  = 1'b1;
                    first_d  = 1'b1;
                    last_d   = (TAPS == 1);
                    done_d   = (TAPS == 1) && (DRAIN_CYCLES == 0);
                end
            end
            STREAM: begin
                if (tap_q == LAST_TAP) begin
                    tap_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = '0;
                        done_d  = (DRAIN_CYCLES == 1);
                    end
                end else begin
                    tap_d    = tap_q + TW'(1);
                    pixel_d  = pix_buf_q[tap_d];
                    weight_d = wt_buf_q[tap_d];
                    valid_d  = 1'b1;
                    last_d   = (tap_d == LAST_TAP);
                    done_d   = last_d && (DRAIN_CYCLES == 0);
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + DW'(1);
                    done_d  = (drain_d == LAST_DRAIN);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            drain_q  <= '0;
            pixel_q  <= '0;
            weight_q <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            drain_q  <= drain_d;
            pixel_q  <= pixel_d;
            weight_q <= weight_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < TAPS; k++) begin
                pix_buf_q[k] <= i_window[k*WIDTH +: WIDTH];
                wt_buf_q[k]  <= i_weights[k*WIDTH +: WIDTH];
            end
        end
    end

    assign o_pixel  = pixel_q;
    assign o_weight = weight_q;
    assign o_valid  = valid_q;
    assign o_first  = first_q;
    assign o_last   = last_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: scoreboarded tap stream for a table of windows, plus reset,
// back-to-back, mid-stream abort and zero-drain sequences.
module tb_conv_window_feeder;
    localparam int W = 32;
    localparam int T = 9;
    localparam int D = 4;

    typedef logic [T*W-1:0] bus_t;
    typedef struct {
        logic [W-1:0] pix;
        logic [W-1:0] wt;
        logic         first;
        logic         last;
    } tap_t;
    typedef struct {
        bus_t         win;
        bus_t         wts;
        logic [W-1:0] exp_first_pix;
        logic [W-1:0] exp_last_pix;
        logic [W-1:0] exp_last_wt;
    } vec_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic i_valid  = 1'b0;
    logic i_valid0 = 1'b0;
    bus_t i_window = '0;
    bus_t i_weights = '0;

    logic         o_ready, o_valid, o_first, o_last, o_done;
    logic [W-1:0] o_pixel, o_weight;
    logic         o_ready0, o_valid0, o_first0, o_last0, o_done0;
    logic [W-1:0] o_pixel0, o_weight0;

    always #5 clk = ~clk;

    conv_window_feeder #(.WIDTH(W), .TAPS(T), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_window(i_window), .i_weights(i_weights),
        .o_pixel(o_pixel), .o_weight(o_weight), .o_valid(o_valid),
        .o_first(o_first), .o_last(o_last), .o_done(o_done)
    );

    conv_window_feeder #(.WIDTH(W), .TAPS(T), .DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .i_valid(i_valid0), .o_ready(o_ready0),
        .i_window(i_window), .i_weights(i_weights),
        .o_pixel(o_pixel0), .o_weight(o_weight0), .o_valid(o_valid0),
        .o_first(o_first0), .o_last(o_last0), .o_done(o_done0)
    );

    int           total = 0;
    int           bad = 0;
    tap_t         exp_q[$];
    tap_t         mon_e;
    bit           mon_en = 1'b0;
    bit           b2b = 1'b0;
    int           since_last = -1;
    int           cyc = 0;
    int           done_cyc = -1;
    logic [W-1:0] seen_first_pix, seen_last_pix, seen_last_wt;
    vec_t         vecs [4];
    logic [W-1:0] px [T];
    logic [W-1:0] wv [T];
    logic [W-1:0] pixf [T] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                               32'h41100000};

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the DRAIN_CYCLES=D instance
    always @(negedge clk) begin
        cyc++;
        if (mon_en && !rst) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tap", W'(1), W'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tap_pixel", o_pixel, mon_e.pix);
                    check("tap_weight", o_weight, mon_e.wt);
                    check("tap_first", W'(o_first), W'(mon_e.first));
                    check("tap_last", W'(o_last), W'(mon_e.last));
                end
                if (o_first) begin
                    seen_first_pix = o_pixel;
                    if (b2b && done_cyc >= 0) check("b2b_gap", W'(cyc - done_cyc), W'(2));
                end
                if (o_last) begin
                    seen_last_pix = o_pixel;
                    seen_last_wt  = o_weight;
                end
            end else begin
                check("idle_pixel_zero", o_pixel, W'(0));
                check("idle_weight_zero", o_weight, W'(0));
                check("idle_flags_zero", W'({o_first, o_last}), W'(0));
            end
            if (o_valid && o_last) since_last = 0;
            else if (since_last >= 0) since_last++;
            if (o_done) begin
                check("done_after_last", W'(since_last), W'(D));
                since_last = -1;
                done_cyc = cyc;
            end else if (since_last > D) begin
                check("done_missing", W'(0), W'(1));
                since_last = -1;
            end
        end
    end

    task automatic send(input bus_t w, input bus_t g, input bit hold);
        bit ok = 1'b0;
        i_window  = w;
        i_weights = g;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = o_ready;
        end
        if (!ok) begin
            check("ready_timeout", W'(0), W'(1));
            i_valid = 1'b0;
            return;
        end
        i_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < T; k++) exp_q.push_back('{w[k*W +: W], g[k*W +: W], k == 0, k == T-1});
        #1;
        if (!hold) i_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = o_done;
        end
        if (!seen) check("done_timeout", W'(0), W'(1));
    endtask

    initial begin
        int  cnt;
        bit  fin;
        // Vector table: test-2 window, special float patterns, two random windows
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < T; k++) begin
                case (v)
                    0: begin px[k] = pixf[k]; wv[k] = pixf[(k+1) % T]; end
                    1: begin
                        px[k] = k[0] ? 32'h7FC00000 : 32'h80000000;
                        wv[k] = k[0] ? 32'hFFFFFFFF : 32'h7F800000;
                    end
                    default: begin px[k] = $urandom; wv[k] = $urandom; end
                endcase
                vecs[v].win[k*W +: W] = px[k];
                vecs[v].wts[k*W +: W] = wv[k];
            end
            vecs[v].exp_first_pix = (v == 0) ? 32'h3F800000 : px[0];
            vecs[v].exp_last_pix  = (v == 0) ? 32'h41100000 : px[T-1];
            vecs[v].exp_last_wt   = (v == 0) ? 32'h3F800000 : wv[T-1];
        end

        // Reset with i_valid asserted
        rst = 1'b1;
        i_valid = 1'b1;
        i_window = vecs[0].win;
        i_weights = vecs[0].wts;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", W'(o_ready), W'(0));
            check("rst_flags", W'({o_valid, o_first, o_last, o_done}), W'(0));
            check("rst_pixel", o_pixel, W'(0));
            check("rst_weight", o_weight, W'(0));
            check("rst_ready0", W'(o_ready0), W'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", W'(o_ready), W'(1));
        mon_en = 1'b1;

        // Table-driven windows with varying idle gaps
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].win, vecs[v].wts, 1'b0);
            wait_done();
            check("vec_first_pix", seen_first_pix, vecs[v].exp_first_pix);
            check("vec_last_pix", seen_last_pix, vecs[v].exp_last_pix);
            check("vec_last_wt", seen_last_wt, vecs[v].exp_last_wt);
            check("vec_q_empty", W'(exp_q.size()), W'(0));
            repeat (v) @(negedge clk);
        end

        // i_valid held high across three windows
        @(posedge clk);
        done_cyc = -1;
        b2b = 1'b1;
        send(vecs[0].win, vecs[0].wts, 1'b1);
        send(vecs[2].win, vecs[2].wts, 1'b1);
        send(vecs[1].win, vecs[1].wts, 1'b0);
        wait_done();
        b2b = 1'b0;
        check("b2b_q_empty", W'(exp_q.size()), W'(0));

        // Reset during tap 4 aborts the window
        send(vecs[0].win, vecs[0].wts, 1'b0);
        fin = 1'b0;
        for (int n = 0; n < 30 && !fin; n++) begin
            @(negedge clk);
            fin = o_valid && (o_pixel == 32'h40A00000);
        end
        if (!fin) check("tap4_timeout", W'(0), W'(1));
        rst = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        check("abort_flags", W'({o_valid, o_first, o_last, o_done}), W'(0));
        check("abort_pixel", o_pixel, W'(0));
        check("abort_weight", o_weight, W'(0));
        rst = 1'b0;
        exp_q.delete();
        since_last = -1;
        mon_en = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(o_done);
        end
        check("abort_no_done", W'(cnt), W'(0));
        check("abort_ready", W'(o_ready), W'(1));
        send(vecs[3].win, vecs[3].wts, 1'b0);
        wait_done();
        check("post_abort_first", seen_first_pix, vecs[3].exp_first_pix);
        check("post_abort_last", seen_last_wt, vecs[3].exp_last_wt);
        check("post_abort_q_empty", W'(exp_q.size()), W'(0));
        mon_en = 1'b0;

        // Zero-drain instance: o_done with o_last, ready on the next cycle
        i_window  = vecs[0].win;
        i_weights = vecs[0].wts;
        @(negedge clk);
        check("d0_ready_idle", W'(o_ready0), W'(1));
        i_valid0 = 1'b1;
        @(posedge clk);
        #1;
        i_valid0 = 1'b0;
        cnt = 0;
        fin = 1'b0;
        for (int n = 0; n < 30 && !fin; n++) begin
            @(negedge clk);
            if (o_valid0) begin
                if (cnt < T) begin
                    check("d0_pixel", o_pixel0, pixf[cnt]);
                    check("d0_weight", o_weight0, pixf[(cnt+1) % T]);
                end
                if (cnt == 0) check("d0_first", W'(o_first0), W'(1));
                cnt++;
                if (o_last0) begin
                    check("d0_done_with_last", W'(o_done0), W'(1));
                    fin = 1'b1;
                end else begin
                    check("d0_no_early_done", W'(o_done0), W'(0));
                end
            end
        end
        if (!fin) check("d0_last_timeout", W'(0), W'(1));
        check("d0_tap_count", W'(cnt), W'(T));
        @(negedge clk);
        check("d0_ready_after", W'(o_ready0), W'(1));
        check("d0_quiet_after", W'({o_valid0, o_done0}), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
